// File: rtl/triphasic_mon.sv
// Triphasic stimulus monitor: times POS1/GAP1/NEG/GAP2/POS2, checks charge balance, strobes protocol errors.
// Optional macro TRIPHASIC_MON_GAPMEAS_EN reports measured gap widths; without it gap1/gap2_width read 0.
module triphasic_mon #(
  parameter int COUNTER_LENGTH = 16,
  parameter int MAX_GAP        = 1000,
  parameter int TOL            = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      A,
  input  logic                      B,
  input  logic                      C,
  output logic                      pulse_valid,
  output logic [COUNTER_LENGTH-1:0] pos1_width,
  output logic [COUNTER_LENGTH-1:0] neg_width,
  output logic [COUNTER_LENGTH-1:0] pos2_width,
  output logic [COUNTER_LENGTH-1:0] gap1_width,
  output logic [COUNTER_LENGTH-1:0] gap2_width,
  output logic                      balance_ok,
  output logic                      err_seq,
  output logic                      err_illegal,
  output logic                      err_timeout,
  output logic                      err_ovf,
  output logic [15:0]               pulse_count
);
  localparam int CW = COUNTER_LENGTH;
  localparam int GW = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);
  localparam int BW = CW + 2;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [GW:0]   GLIM = (GW + 1)'(MAX_GAP);
  localparam bit TO_ON_ENTRY = (MAX_GAP <= 1);

  typedef enum logic [2:0] {IDLE, POS1, GAP1, NEG, GAP2, POS2} state_t;
  state_t state, state_nxt;

  logic is_pos, is_neg, is_gap, legal;
  assign is_pos = ({A, B, C} == 3'b100);
  assign is_neg = ({A, B, C} == 3'b010);
  assign is_gap = ({A, B, C} == 3'b001);
  assign legal  = is_pos | is_neg | is_gap;

  logic [CW-1:0] p1_cnt, n_cnt, p2_cnt;
  logic [GW-1:0] gap_cnt;
  logic [GW:0]   gap_inc;
  logic          gap_hit, sat_seen, phase_entry, gap_entry;
  logic          ev_seq, ev_ill, ev_to, ev_done;
  logic          inc_p1, inc_n, inc_p2, inc_sat;
  logic          seq_d, ill_d, to_d, ovf_d;

  // Gap timeout counter is sized by MAX_GAP, independent of the width counters.
  assign gap_inc = {1'b0, gap_cnt} + (GW + 1)'(1);
  assign gap_hit = (gap_inc >= GLIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ev_seq    = 1'b0;
    ev_ill    = 1'b0;
    ev_to     = 1'b0;
    ev_done   = 1'b0;
    if (!legal) begin
      ev_ill    = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_pos)      state_nxt = POS1;
          else if (is_neg) ev_seq = 1'b1;
        end
        POS1: begin
          if (is_gap) begin
            if (TO_ON_ENTRY) begin ev_to = 1'b1; state_nxt = IDLE; end
            else state_nxt = GAP1;
          end else if (is_neg) state_nxt = NEG;
        end
        GAP1: begin
          if (is_gap && gap_hit) begin ev_to = 1'b1; state_nxt = IDLE; end
          else if (is_neg)       state_nxt = NEG;
          else if (is_pos)       begin ev_seq = 1'b1; state_nxt = IDLE; end
        end
        NEG: begin
          if (is_gap) begin
            if (TO_ON_ENTRY) begin ev_to = 1'b1; state_nxt = IDLE; end
            else state_nxt = GAP2;
          end else if (is_pos) state_nxt = POS2;
        end
        GAP2: begin
          if (is_gap && gap_hit) begin ev_to = 1'b1; state_nxt = IDLE; end
          else if (is_pos)       state_nxt = POS2;
          else if (is_neg)       begin ev_seq = 1'b1; state_nxt = IDLE; end
        end
        POS2: begin
          if (is_gap)      begin ev_done = 1'b1; state_nxt = IDLE; end
          else if (is_neg) begin ev_seq = 1'b1; state_nxt = IDLE; end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    inc_p1      = (state == POS1) && is_pos;
    inc_n       = (state == NEG)  && is_neg;
    inc_p2      = (state == POS2) && is_pos;
    inc_sat     = (inc_p1 && (p1_cnt == CMAX)) || (inc_n && (n_cnt == CMAX)) ||
                  (inc_p2 && (p2_cnt == CMAX));
    phase_entry = (state_nxt != state) &&
                  ((state_nxt == POS1) || (state_nxt == NEG) || (state_nxt == POS2));
    gap_entry   = ((state == POS1) && (state_nxt == GAP1)) ||
                  ((state == NEG)  && (state_nxt == GAP2));
    ill_d       = ev_ill;
    seq_d       = ev_seq && !ev_ill;
    to_d        = ev_to && !ev_ill && !ev_seq;
    ovf_d       = inc_sat && !sat_seen && !ev_ill && !ev_seq && !ev_to;
  end

  // Intermediates carry two spare bits so p1+p2-n never wraps.
  logic signed [BW-1:0] diff;
  logic [BW-1:0]        mag;
  logic                 balanced;
  assign diff     = $signed({2'b00, p1_cnt}) + $signed({2'b00, p2_cnt}) - $signed({2'b00, n_cnt});
  assign mag      = diff[BW-1] ? $unsigned(-diff) : $unsigned(diff);
  assign balanced = (mag <= BW'(TOL));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_cnt   <= '0;
      n_cnt    <= '0;
      p2_cnt   <= '0;
      gap_cnt  <= '0;
      sat_seen <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_nxt == POS1)) p1_cnt <= CONE;
      else if (inc_p1 && (p1_cnt != CMAX))       p1_cnt <= p1_cnt + CONE;
      if ((state_nxt == NEG) && (state != NEG))   n_cnt <= CONE;
      else if (inc_n && (n_cnt != CMAX))          n_cnt <= n_cnt + CONE;
      if ((state_nxt == POS2) && (state != POS2)) p2_cnt <= CONE;
      else if (inc_p2 && (p2_cnt != CMAX))        p2_cnt <= p2_cnt + CONE;
      if (gap_entry) gap_cnt <= GW'(1);
      else if (((state == GAP1) || (state == GAP2)) && is_gap && !gap_hit) gap_cnt <= gap_inc[GW-1:0];
      // One overflow strobe per phase: the flag re-arms whenever a new phase starts.
      if (inc_sat)          sat_seen <= 1'b1;
      else if (phase_entry) sat_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_valid <= 1'b0;
      err_seq     <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      pos1_width  <= '0;
      neg_width   <= '0;
      pos2_width  <= '0;
      balance_ok  <= 1'b0;
      pulse_count <= '0;
    end else begin
      pulse_valid <= ev_done;
      err_seq     <= seq_d;
      err_illegal <= ill_d;
      err_timeout <= to_d;
      err_ovf     <= ovf_d;
      if (ev_done) begin
        pos1_width  <= p1_cnt;
        neg_width   <= n_cnt;
        pos2_width  <= p2_cnt;
        balance_ok  <= balanced;
        pulse_count <= pulse_count + 16'd1;
      end
    end
  end

`ifdef TRIPHASIC_MON_GAPMEAS_EN
  localparam int XW = (GW > CW) ? GW : CW;
  logic [XW-1:0] gap_x;
  logic [CW-1:0] gap_sat, g1_len, g2_len;
  assign gap_x   = XW'(gap_cnt);
  assign gap_sat = (gap_x > XW'(CMAX)) ? CMAX : gap_x[CW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g1_len     <= '0;
      g2_len     <= '0;
      gap1_width <= '0;
      gap2_width <= '0;
    end else begin
      if ((state == POS1) && (state_nxt == NEG))      g1_len <= '0;
      else if ((state == GAP1) && (state_nxt == NEG)) g1_len <= gap_sat;
      if ((state == NEG) && (state_nxt == POS2))      g2_len <= '0;
      else if ((state == GAP2) && (state_nxt == POS2)) g2_len <= gap_sat;
      if (ev_done) begin
        gap1_width <= g1_len;
        gap2_width <= g2_len;
      end
    end
  end
`else
  assign gap1_width = '0;
  assign gap2_width = '0;
`endif

endmodule

// File: tb/tb_triphasic_mon.sv
// Directed bench for triphasic_mon: a 16-bit instance for function/errors and a 4-bit instance for saturation.
module tb_triphasic_mon;
`ifdef TRIPHASIC_MON_GAPMEAS_EN
  localparam bit GM = 1'b1;
`else
  localparam bit GM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b1;

  logic        pulse_valid, balance_ok, err_seq, err_illegal, err_timeout, err_ovf;
  logic [15:0] pos1_width, neg_width, pos2_width, gap1_width, gap2_width, pulse_count;
  logic        s_pulse_valid, s_balance_ok, s_err_seq, s_err_illegal, s_err_timeout, s_err_ovf;
  logic [3:0]  s_pos1_width, s_neg_width, s_pos2_width, s_gap1_width, s_gap2_width;
  logic [15:0] s_pulse_count;

  int tests = 0, fails = 0;
  int n_valid = 0, n_seq = 0, n_ill = 0, n_to = 0, n_ovf = 0, n_multi = 0, n_ovf4 = 0;
  int exp_cnt = 0;
  int v0, s0, i0, t0, o0;

  always #5 clk = ~clk;

  triphasic_mon #(.COUNTER_LENGTH(16), .MAX_GAP(1000), .TOL(2)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .C(c),
    .pulse_valid(pulse_valid), .pos1_width(pos1_width), .neg_width(neg_width), .pos2_width(pos2_width),
    .gap1_width(gap1_width), .gap2_width(gap2_width), .balance_ok(balance_ok),
    .err_seq(err_seq), .err_illegal(err_illegal), .err_timeout(err_timeout), .err_ovf(err_ovf),
    .pulse_count(pulse_count));

  triphasic_mon #(.COUNTER_LENGTH(4), .MAX_GAP(1000), .TOL(2)) dut4 (
    .clk(clk), .reset(reset), .A(a), .B(b), .C(c),
    .pulse_valid(s_pulse_valid), .pos1_width(s_pos1_width), .neg_width(s_neg_width), .pos2_width(s_pos2_width),
    .gap1_width(s_gap1_width), .gap2_width(s_gap2_width), .balance_ok(s_balance_ok),
    .err_seq(s_err_seq), .err_illegal(s_err_illegal), .err_timeout(s_err_timeout), .err_ovf(s_err_ovf),
    .pulse_count(s_pulse_count));

  always @(negedge clk) begin
    if (pulse_valid) n_valid++;
    if (err_seq) n_seq++;
    if (err_illegal) n_ill++;
    if (err_timeout) n_to++;
    if (err_ovf) n_ovf++;
    if (s_err_ovf) n_ovf4++;
    if ((int'(err_seq) + int'(err_illegal) + int'(err_timeout) + int'(err_ovf)) > 1) n_multi++;
  end

  task automatic send(input logic [2:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      {a, b, c} = code;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input int p1, input int g1, input int n, input int g2, input int p2);
    send(3'b100, p1); send(3'b001, g1); send(3'b010, n); send(3'b001, g2); send(3'b100, p2); send(3'b001, 1);
  endtask

  task automatic snap();
    #1; v0 = n_valid; s0 = n_seq; i0 = n_ill; t0 = n_to; o0 = n_ovf;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (pulse_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", pulse_valid); end
    tests++; if ({pos1_width, neg_width, pos2_width} !== 48'd0) begin fails++; $display("FAIL reset_widths: got %0d/%0d/%0d expected 0/0/0", pos1_width, neg_width, pos2_width); end
    tests++; if ({gap1_width, gap2_width} !== 32'd0) begin fails++; $display("FAIL reset_gaps: got %0d/%0d expected 0/0", gap1_width, gap2_width); end
    tests++; if ({balance_ok, err_seq, err_illegal, err_timeout, err_ovf} !== 5'd0) begin fails++; $display("FAIL reset_flags: got %b expected 00000", {balance_ok, err_seq, err_illegal, err_timeout, err_ovf}); end
    tests++; if (pulse_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", pulse_count); end
    reset = 1'b1;
    send(3'b001, 3);
  endtask

  task automatic test_nominal();
    snap();
    pulse(100, 10, 200, 10, 100);
    exp_cnt++;
    tests++; if (pulse_valid !== 1'b1) begin fails++; $display("FAIL nom_valid: got %b expected 1", pulse_valid); end
    tests++; if ({pos1_width, neg_width, pos2_width} !== {16'd100, 16'd200, 16'd100}) begin fails++; $display("FAIL nom_widths: got %0d/%0d/%0d expected 100/200/100", pos1_width, neg_width, pos2_width); end
    tests++; if ({gap1_width, gap2_width} !== (GM ? {16'd10, 16'd10} : 32'd0)) begin fails++; $display("FAIL nom_gaps: got %0d/%0d expected %0d/%0d", gap1_width, gap2_width, GM ? 10 : 0, GM ? 10 : 0); end
    tests++; if (balance_ok !== 1'b1) begin fails++; $display("FAIL nom_balance: got %b expected 1", balance_ok); end
    tests++; if (pulse_count !== 16'(exp_cnt)) begin fails++; $display("FAIL nom_count: got %0d expected %0d", pulse_count, exp_cnt); end
    send(3'b001, 1);
    tests++; if (pulse_valid !== 1'b0 || pos1_width !== 16'd100) begin fails++; $display("FAIL nom_one_cycle: got valid=%b pos1=%0d expected valid=0 pos1=100", pulse_valid, pos1_width); end
    send(3'b001, 3); #1;
    tests++; if ((n_valid - v0) != 1 || (n_seq + n_ill + n_to + n_ovf) != (s0 + i0 + t0 + o0)) begin fails++; $display("FAIL nom_strobes: got valid=%0d errs=%0d expected valid=1 errs=0", n_valid - v0, (n_seq + n_ill + n_to + n_ovf) - (s0 + i0 + t0 + o0)); end
  endtask

  task automatic test_balance();
    pulse(100, 10, 205, 10, 100); exp_cnt++;
    tests++; if (pulse_valid !== 1'b1 || balance_ok !== 1'b0 || neg_width !== 16'd205) begin fails++; $display("FAIL bal_205: got valid=%b ok=%b neg=%0d expected valid=1 ok=0 neg=205", pulse_valid, balance_ok, neg_width); end
    send(3'b001, 2);
    pulse(100, 10, 202, 10, 100); exp_cnt++;
    tests++; if (pulse_valid !== 1'b1 || balance_ok !== 1'b1) begin fails++; $display("FAIL bal_202: got valid=%b ok=%b expected valid=1 ok=1", pulse_valid, balance_ok); end
    send(3'b001, 2);
    pulse(100, 10, 197, 10, 100); exp_cnt++;
    tests++; if (pulse_valid !== 1'b1 || balance_ok !== 1'b0) begin fails++; $display("FAIL bal_197: got valid=%b ok=%b expected valid=1 ok=0", pulse_valid, balance_ok); end
    send(3'b001, 2);
  endtask

  task automatic test_no_gaps();
    pulse(5, 0, 10, 0, 5); exp_cnt++;
    tests++; if ({pos1_width, neg_width, pos2_width} !== {16'd5, 16'd10, 16'd5} || balance_ok !== 1'b1) begin fails++; $display("FAIL nogap_widths: got %0d/%0d/%0d ok=%b expected 5/10/5 ok=1", pos1_width, neg_width, pos2_width, balance_ok); end
    tests++; if ({gap1_width, gap2_width} !== 32'd0 || pulse_count !== 16'(exp_cnt)) begin fails++; $display("FAIL nogap_gaps: got %0d/%0d cnt=%0d expected 0/0 cnt=%0d", gap1_width, gap2_width, pulse_count, exp_cnt); end
    send(3'b001, 2);
  endtask

  task automatic test_illegal();
    snap();
    send(3'b100, 10); send(3'b001, 2); send(3'b010, 5); send(3'b110, 1);
    tests++; if (err_illegal !== 1'b1 || err_seq !== 1'b0) begin fails++; $display("FAIL ill_strobe: got ill=%b seq=%b expected ill=1 seq=0", err_illegal, err_seq); end
    send(3'b001, 1);
    tests++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL ill_one_cycle: got %b expected 0", err_illegal); end
    send(3'b001, 2); #1;
    tests++; if (n_valid != v0 || neg_width !== 16'd10 || pulse_count !== 16'(exp_cnt)) begin fails++; $display("FAIL ill_discard: got valids=%0d neg=%0d cnt=%0d expected 0 10 %0d", n_valid - v0, neg_width, pulse_count, exp_cnt); end
    pulse(30, 3, 60, 3, 30); exp_cnt++;
    tests++; if (pulse_valid !== 1'b1 || {pos1_width, neg_width, pos2_width} !== {16'd30, 16'd60, 16'd30} || pulse_count !== 16'(exp_cnt)) begin fails++; $display("FAIL ill_recover: got valid=%b %0d/%0d/%0d cnt=%0d expected 1 30/60/30 cnt=%0d", pulse_valid, pos1_width, neg_width, pos2_width, pulse_count, exp_cnt); end
    send(3'b001, 2);
  endtask

  task automatic test_seq();
    send(3'b010, 1);
    tests++; if (err_seq !== 1'b1) begin fails++; $display("FAIL seq_idle_neg: got %b expected 1", err_seq); end
    send(3'b100, 3); send(3'b001, 2); send(3'b100, 1);
    tests++; if (err_seq !== 1'b1) begin fails++; $display("FAIL seq_gap1_pos: got %b expected 1", err_seq); end
    pulse(7, 0, 14, 0, 7); exp_cnt++;
    tests++; if (pulse_valid !== 1'b1 || {pos1_width, neg_width, pos2_width} !== {16'd7, 16'd14, 16'd7}) begin fails++; $display("FAIL seq_no_dead_cycle: got valid=%b %0d/%0d/%0d expected 1 7/14/7", pulse_valid, pos1_width, neg_width, pos2_width); end
    send(3'b001, 2);
  endtask

  task automatic test_timeout();
    snap();
    send(3'b100, 50); send(3'b001, 999);
    tests++; if (err_timeout !== 1'b0 || n_to != t0) begin fails++; $display("FAIL to_gap1_999: got strobe=%b count=%0d expected 0 0", err_timeout, n_to - t0); end
    send(3'b001, 1);
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL to_gap1_1000: got %b expected 1", err_timeout); end
    send(3'b100, 5); send(3'b010, 5); send(3'b001, 1000);
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL to_gap2_1000: got %b expected 1", err_timeout); end
    send(3'b001, 3); #1;
    tests++; if (n_valid != v0 || (n_to - t0) != 2 || pulse_count !== 16'(exp_cnt)) begin fails++; $display("FAIL to_discard: got valids=%0d timeouts=%0d cnt=%0d expected 0 2 %0d", n_valid - v0, n_to - t0, pulse_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    send(3'b100, 10); send(3'b001, 2); send(3'b010, 20); send(3'b001, 2); send(3'b100, 5);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (pulse_count !== 16'd0 || {pos1_width, neg_width, pos2_width, gap1_width, gap2_width} !== 80'd0 || balance_ok !== 1'b0) begin fails++; $display("FAIL rstmid_clear: got cnt=%0d pos1=%0d ok=%b expected 0 0 0", pulse_count, pos1_width, balance_ok); end
    {a, b, c} = 3'b001;
    reset = 1'b1;
    snap();
    send(3'b001, 3); #1;
    tests++; if ((n_seq + n_ill + n_to + n_ovf) != (s0 + i0 + t0 + o0)) begin fails++; $display("FAIL rstmid_no_err: got %0d strobes expected 0", (n_seq + n_ill + n_to + n_ovf) - (s0 + i0 + t0 + o0)); end
    exp_cnt = 0;
    pulse(4, 1, 8, 1, 4); exp_cnt++;
    tests++; if (pulse_count !== 16'd1 || {pos1_width, neg_width, pos2_width} !== {16'd4, 16'd8, 16'd4}) begin fails++; $display("FAIL rstmid_pulse: got cnt=%0d %0d/%0d/%0d expected 1 4/8/4", pulse_count, pos1_width, neg_width, pos2_width); end
    send(3'b001, 2);
  endtask

  task automatic test_ovf();
    int base4;
    #1; base4 = n_ovf4;
    send(3'b100, 15);
    tests++; if (s_err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_at_15: got %b expected 0", s_err_ovf); end
    send(3'b100, 1);
    tests++; if (s_err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_at_16: got %b expected 1", s_err_ovf); end
    send(3'b100, 4); send(3'b001, 1); send(3'b010, 10); send(3'b001, 1); send(3'b100, 5); send(3'b001, 1);
    exp_cnt++;
    tests++; if (s_pulse_valid !== 1'b1 || {s_pos1_width, s_neg_width, s_pos2_width} !== {4'd15, 4'd10, 4'd5}) begin fails++; $display("FAIL ovf_widths: got valid=%b %0d/%0d/%0d expected 1 15/10/5", s_pulse_valid, s_pos1_width, s_neg_width, s_pos2_width); end
    tests++; if (pulse_valid !== 1'b1 || pos1_width !== 16'd20 || balance_ok !== 1'b0) begin fails++; $display("FAIL ovf_wide_dut: got valid=%b pos1=%0d ok=%b expected 1 20 0", pulse_valid, pos1_width, balance_ok); end
    send(3'b001, 2); #1;
    tests++; if ((n_ovf4 - base4) != 1) begin fails++; $display("FAIL ovf_once: got %0d strobes expected 1", n_ovf4 - base4); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_balance();
    test_no_gaps();
    test_illegal();
    test_seq();
    test_timeout();
    test_reset_mid();
    test_ovf();
    #1;
    tests++; if (n_multi != 0 || n_ovf != 0) begin fails++; $display("FAIL err_exclusive: got multi=%0d wide_ovf=%0d expected 0 0", n_multi, n_ovf); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
